sub_bytes_iter: RTL
===================

// Module: sub_bytes_iter
// PURPOSE
//  Iterative, parametrised AES SubBytes engine. Accepts a NUM_BYTES-byte state over a
//  valid/ready handshake and substitutes LANES bytes per cycle through LANES S-box lookups.
//  Sits between AddRoundKey and ShiftRows in the round datapath. Trades latency for S-box area.
//  Optionally also performs InvSubBytes for the decryption path.
// PARAMETERS
//  NUM_BYTES  16  bytes per state word; the data width is 8*NUM_BYTES.
//  LANES      4   S-box lookups per cycle. NUM_BYTES % LANES must be 0; otherwise elaboration fails.
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   1            input state word is valid
//  in_ready   out  1            engine can accept a word
//  in_inv     in   1            1 = inverse S-box. Sampled on accept.
//  state      in   8*NUM_BYTES  input word; byte i is at bits [8i+7:8i]
//  out_valid  out  1            newState is valid
//  out_ready  in   1            downstream accepts newState
//  newState   out  8*NUM_BYTES  substituted word; byte order matches state
//  busy       out  1            high in BUSY and DONE
// BEHAVIOUR
//  Single clock domain. Reset is asynchronous and active-high. BEATS = NUM_BYTES/LANES.
//  Counter cnt is max($clog2(BEATS),1) bits wide.
//  FSM states: IDLE, BUSY, DONE.
//  - IDLE: in_ready=1. On in_valid: load buf<=state, mode<=in_inv, cnt<=0, go to BUSY.
//  - BUSY: each cycle, buf bytes [cnt*LANES +: LANES] <= Sbox(byte).
//    If cnt==BEATS-1, go to DONE; otherwise cnt++. in_ready=0.
//  - DONE: out_valid=1 and newState=buf, held stable until out_ready.
//    On out_ready with in_valid=0: go to IDLE.
//    On out_ready with in_valid=1: accept the new word in the same cycle and go to BUSY (back-to-back).
//  - in_ready = (IDLE) | (DONE & out_ready).
//  Latency: out_valid rises exactly BEATS cycles after the accepting edge.
//  Throughput: one word per BEATS+1 cycles when out_ready is held high.
//  - BEATS==1 (LANES==NUM_BYTES): BUSY lasts one cycle.
//  Input state is captured on accept; changes on state or in_inv after accept have no effect.
//  Reset values: out_valid=0, newState=0, busy=0, in_ready=1, FSM=IDLE, cnt=0, mode=0.
//  Reset asserted mid-BUSY or mid-DONE discards the word immediately; no partial output is presented.
// CONFIGURATION
//  SUB_BYTES_INV_EN defined:
//    - the inverse S-box table is compiled in;
//    - mode=1 selects InvSbox for every lane of the word.
//  SUB_BYTES_INV_EN undefined:
//    - only the forward table is built;
//    - in_inv is ignored and mode is forced to 0.
//  The port list is identical in both builds.
// STRUCTURE
//  aes_pkg:
//    - SBOX_FWD[256], SBOX_INV[256] as 8-bit constant arrays;
//    - sbox_lookup(byte, inv) function;
//    - fsm state enum sb_state_t.
//  Sub-module sbox_lane: one combinational byte lookup (data_in, inv, data_out).
//    Generate-instantiated LANES times.
//  Lane mux selects bytes by cnt; write-back is a byte-enable update of buf.
// TESTING
//  1. LANES=4, accept state=128'h0f0e0d0c0b0a09080706050403020100, inv=0
//     -> out_valid exactly 4 cycles later, newState=128'h76abd7fe2b670130c56f6bf27b777c63.
//  2. All bytes 8'h52 -> all 8'h00. All bytes 8'hff -> all 8'h16.
//     Repeat with LANES=1 (latency 16) and LANES=16 (latency 1).
//  3. SUB_BYTES_INV_EN defined, inv=1, state=128'h76abd7fe2b670130c56f6bf27b777c63
//     -> 128'h0f0e...0100. Undefined build, same stimulus -> forward result; in_inv is ignored.
//  4. Backpressure: out_ready=0 for 10 cycles in DONE -> newState stable, in_ready=0.
//     Then out_ready=1 with in_valid=1 -> next word accepted that cycle, out_valid falls next cycle.
//  5. Assert rst 2 cycles after accept -> out_valid=0, newState=0, in_ready=1 immediately.
//     A new word after release gives a correct result.
//  6. Stream 50 random words with random in_valid/out_ready
//     -> every output matches the package-function model, in order, none dropped or duplicated.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the iterative SubBytes engine:
//     - SBOX_FWD / SBOX_INV : AES S-box and inverse S-box as 8-bit constant tables
//     - sbox_lookup()       : single-byte substitution, forward or inverse
//     - sb_state_t          : engine FSM states
//   Build option: SUB_BYTES_INV_EN compiles in the inverse table. Without it only
//   the forward table exists and the inverse select is ignored.
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_DONE = 2'd2
    } sb_state_t;

`ifdef SUB_BYTES_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef SUB_BYTES_INV_EN
    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

    // Single-byte substitution. inv=1 selects the inverse table when it is built.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
`ifdef SUB_BYTES_INV_EN
        return inv ? SBOX_INV[b] : SBOX_FWD[b];
`else
        // Forward-only build: INV_EN is 0, so the select never changes the result.
        return (inv && INV_EN) ? 8'h00 : SBOX_FWD[b];
`endif
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// -----------------------------------------------------------------------------
// sbox_lane
//   One combinational S-box lookup lane.
//   Ports:
//     data_in  [7:0]  byte to substitute
//     inv             1 = inverse S-box (only effective with SUB_BYTES_INV_EN)
//     data_out [7:0]  substituted byte
// -----------------------------------------------------------------------------
module sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] data_in,
    input  logic       inv,
    output logic [7:0] data_out
);

    assign data_out = sbox_lookup(data_in, inv);

endmodule

// File: rtl/sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// sub_bytes_iter
//   Iterative AES SubBytes / InvSubBytes engine. A NUM_BYTES-byte word is taken
//   over a valid/ready handshake and substituted LANES bytes per cycle, so a
//   word takes BEATS = NUM_BYTES/LANES cycles in BUSY, then is held in DONE
//   until the consumer takes it. DONE with out_ready may accept the next word
//   in the same cycle.
//   Build option: SUB_BYTES_INV_EN enables the inverse S-box (in_inv sampled
//   on accept); without it in_inv is ignored and every word is forward-mapped.
//   Ports:
//     clk, rst             clock (rising edge), asynchronous active-high reset
//     in_valid / in_ready  input handshake; in_inv and state captured on accept
//     state    [8*NB-1:0]  input word, byte i at [8i+7:8i]
//     out_valid/out_ready  output handshake
//     newState [8*NB-1:0]  substituted word, valid only while out_valid
//     busy                 high while a word is held (BUSY or DONE)
// -----------------------------------------------------------------------------
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [8*NUM_BYTES-1:0] state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] newState,
    output logic                   busy
);

    localparam int BEATS = NUM_BYTES / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if ((LANES < 1) || ((NUM_BYTES % LANES) != 0)) begin : g_bad_cfg
        $error("sub_bytes_iter: NUM_BYTES must be a positive multiple of LANES");
    end

    sb_state_t              r_fsm;
    sb_state_t              w_fsm_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [8*NUM_BYTES-1:0] r_buf;
    logic [8*NUM_BYTES-1:0] w_buf_upd;
    logic                   r_mode;
    logic                   w_accept;
    logic                   w_last;
    logic [7:0]             w_lane_in  [LANES];
    logic [7:0]             w_lane_out [LANES];

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == LAST_CNT);

    // ---------------------------------------------------------------- FSM
    // NOTE: state-holding processes use non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= SB_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_fsm_next = r_fsm;
        unique case (r_fsm)
            SB_IDLE: if (in_valid) w_fsm_next = SB_BUSY;
            SB_BUSY: if (w_last)   w_fsm_next = SB_DONE;
            SB_DONE: if (out_ready) w_fsm_next = in_valid ? SB_BUSY : SB_IDLE;
            default: w_fsm_next = SB_IDLE;
        endcase
    end

    // newState is forced to zero outside DONE so a partly substituted word
    // is never visible on the port.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        newState  = '0;
        unique case (r_fsm)
            SB_IDLE: in_ready = 1'b1;
            SB_BUSY: busy = 1'b1;
            SB_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                in_ready  = out_ready;
                newState  = r_buf;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // Lane mux: lane l sees byte cnt*LANES + l of the working buffer.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_in[l] = 8'h00;
        end
        for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    w_lane_in[l] = r_buf[8*(b*LANES + l) +: 8];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox_lane u_lane (
            .data_in  (w_lane_in[l]),
            .inv      (r_mode),
            .data_out (w_lane_out[l])
        );
    end

    // Byte-enable write-back: only the LANES bytes of the current beat change.
    always_comb begin
        w_buf_upd = r_buf;
        for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    w_buf_upd[8*(b*LANES + l) +: 8] = w_lane_out[l];
                end
            end
        end
    end

    // NOTE: the word buffer is reset even though it is datapath storage,
    // because it drives newState and must read as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf  <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_buf  <= state;
            r_cnt  <= '0;
            r_mode <= in_inv & INV_EN;
        end else if (r_fsm == SB_BUSY) begin
            r_buf <= w_buf_upd;
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
